// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the systolic array datapath blocks.
//  - DIM_DEFAULT:   default array dimension, shared with the systolic controller.
//  - drain_state_t: state encoding of the result-drain FSM.
//  - narrow():      per-lane narrowing of a sign-extended accumulator value.
// Build option: SYSTOLIC_DRAIN_SAT_EN selects saturating narrowing; when it is
// undefined, narrow() truncates and no saturation logic is compiled in.
package systolic_pkg;

  localparam int unsigned DIM_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } drain_state_t;

  // val is the lane value sign-extended to 64 bits; the caller keeps the low
  // out_w bits of the result. Lane widths are therefore limited to 64 bits.
  function automatic logic [63:0] narrow(input logic signed [63:0] val,
                                         input int unsigned        out_w);
    logic [63:0] res;
`ifdef SYSTOLIC_DRAIN_SAT_EN
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (val > max_v) begin
      res = max_v;
    end else if (val < min_v) begin
      res = min_v;
    end else begin
      res = val;
    end
`else
    // A shift by 64 yields 0, so the mask becomes all ones for out_w == 64.
    res = val & ((64'd1 << out_w) - 64'd1);
`endif
    return res;
  endfunction

endpackage

// File: rtl/systolic_row_fifo.sv
// systolic_row_fifo: small row FIFO with a registered head entry.
// Ports:
//  clk, rst       clock, asynchronous active-low reset
//  push, wdata    write a row (accepted when not full, or when popping at full)
//  pop, rdata     rdata is the head entry, valid while empty is low
//  full, empty    occupancy flags
//  count          number of stored entries (0..DEPTH)
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module systolic_row_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // At full, a pop in the same cycle frees the slot being written.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: unloads DIM result rows from the systolic array after compute.
// After a start pulse it pulls one row per cycle (shift_en), buffers the rows in a
// row FIFO, narrows every lane from ACC_W to OUT_W and streams the rows out on a
// valid/ready interface with out_last on the final row, then pulses done.
// Ports:
//  clk, rst             clock, asynchronous active-low reset
//  start                1-cycle pulse, begin a drain (ignored unless idle)
//  row_in               array output row, lane j at [j*ACC_W +: ACC_W]
//  shift_en             advance the array; row_in is captured in the same cycle
//  busy                 high while draining or flushing
//  out_valid/out_ready  row handshake; out_data lane j at [j*OUT_W +: OUT_W]
//  out_last             marks row DIM-1
//  done                 1-cycle pulse after the last row is accepted
// Build option: SYSTOLIC_DRAIN_SAT_EN selects saturating narrowing (see systolic_pkg).
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int unsigned DIM   = DIM_DEFAULT,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM*ACC_W-1:0]   row_in,
  output logic                   shift_en,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIM*OUT_W-1:0]   out_data,
  output logic                   out_last,
  output logic                   done
);

  localparam int unsigned W    = DIM * OUT_W + 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned RowW = $clog2(DIM);

  drain_state_t         state_q;
  logic [RowW-1:0]      row_cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pop;
  logic                 last_tag;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CntW-1:0]      fifo_count;
  logic [W-1:0]         fifo_rdata;
  logic [DIM*OUT_W-1:0] row_nar;

  assign pop       = out_valid & out_ready;
  assign last_tag  = (row_cnt_q == RowW'(DIM - 1));
  // A pop in the same cycle frees a slot, so a full FIFO does not stall the array.
  assign shift_en  = (state_q == DRAIN) & ((fifo_count < CntW'(DEPTH)) | pop);
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rdata[W-2:0];
  assign out_last  = out_valid & fifo_rdata[W-1];
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    row_nar = '0;
    for (int unsigned j = 0; j < DIM; j++) begin
      row_nar[j*OUT_W +: OUT_W] =
          OUT_W'(narrow(64'(signed'(row_in[j*ACC_W +: ACC_W])), OUT_W));
    end
  end

  systolic_row_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (shift_en),
    .pop   (pop),
    .wdata ({last_tag, row_nar}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= DRAIN;
            row_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        DRAIN: begin
          if (shift_en) begin
            row_cnt_q <= row_cnt_q + RowW'(1);
            if (last_tag) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (pop && fifo_rdata[W-1]) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // shift_en must never push into a full FIFO without a matching pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                  shift_en |-> (!fifo_full || pop));

endmodule
